// File: rtl/demux_sched_pkg.sv
// rtl/demux_sched_pkg.sv - shared state encoding and lane/mode constants for the lane scheduler
package demux_sched_pkg;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_e;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  localparam logic RR    = 1'b0;
  localparam logic FIXED = 1'b1;

  // Round-robin prefers the lane that was not used last.
  function automatic logic other_lane(input logic lane);
    return ~lane;
  endfunction

endpackage

// File: rtl/demux_lane_sched_if.sv
// rtl/demux_lane_sched_if.sv - upstream/config/downstream bundle of the lane scheduler
interface demux_lane_sched_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);

  logic              init;
  logic              mode_cfg;
  logic              fixed_lane_cfg;
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic              full0;
  logic              full1;

  logic              ready_out;
  logic              selector;
  logic              valid_out;
  logic [DATA_W-1:0] data_out;
  logic [CNT_W-1:0]  count0;
  logic [CNT_W-1:0]  count1;
  logic              idle_out;

  modport master (
    output init, mode_cfg, fixed_lane_cfg, valid_in, data_in, full0, full1,
    input  ready_out, selector, valid_out, data_out, count0, count1, idle_out
  );

  modport slave (
    input  init, mode_cfg, fixed_lane_cfg, valid_in, data_in, full0, full1,
    output ready_out, selector, valid_out, data_out, count0, count1, idle_out
  );

endinterface

// File: rtl/demux_lane_pick.sv
// rtl/demux_lane_pick.sv - combinational lane choice and readiness from mode, pointer and pause inputs
module demux_lane_pick
  import demux_sched_pkg::*;
(
  input  logic mode_i,
  input  logic fixed_lane_i,
  input  logic last_lane_i,
  input  logic full0_i,
  input  logic full1_i,
  output logic lane_o,
  output logic ready_o
);

  logic pref_lane;
  logic pref_full;

  // Fixed mode only looks at its own lane; round-robin falls back to the other lane when the preferred one pauses.
  always_comb begin
    pref_lane = other_lane(last_lane_i);
    pref_full = (pref_lane == LANE1) ? full1_i : full0_i;
    if (mode_i == FIXED) begin
      lane_o  = fixed_lane_i;
      ready_o = (fixed_lane_i == LANE1) ? !full1_i : !full0_i;
    end else begin
      lane_o  = pref_full ? last_lane_i : pref_lane;
      ready_o = !(full0_i && full1_i);
    end
  end

endmodule

// File: rtl/demux_lane_sched.sv
// rtl/demux_lane_sched.sv - schedules an upstream byte stream onto two downstream lanes via a 1:2 demux
module demux_lane_sched
  import demux_sched_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input logic              clk_2f,
  input logic              reset,
  demux_lane_sched_if.slave bus
);

  state_e            state_q;
  logic              mode_q;
  logic              lane_cfg_q;
  logic              last_q;
  logic              sel_q;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt0_q;
  logic [CNT_W-1:0]  cnt1_q;
  logic [CNT_W-1:0]  cnt0_d;
  logic [CNT_W-1:0]  cnt1_d;

  logic pick_lane;
  logic pick_ready;
  logic running;
  logic ready;
  logic xfer;

  demux_lane_pick u_pick (
    .mode_i       (mode_q),
    .fixed_lane_i (lane_cfg_q),
    .last_lane_i  (last_q),
    .full0_i      (bus.full0),
    .full1_i      (bus.full1),
    .lane_o       (pick_lane),
    .ready_o      (pick_ready)
  );

  // Accept only while running and not being pulled back into INIT or reset.
  always_comb begin
    running = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    ready   = running && !bus.init && !reset && pick_ready;
    xfer    = bus.valid_in && ready;
    cnt0_d  = (xfer && (pick_lane == LANE0)) ? cnt0_q + 1'b1 : cnt0_q;
    cnt1_d  = (xfer && (pick_lane == LANE1)) ? cnt1_q + 1'b1 : cnt1_q;
  end

  // Control FSM with registered demux outputs and per-lane counters.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state_q    <= ST_RESET;
      valid_q    <= 1'b0;
      sel_q      <= LANE0;
      data_q     <= '0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      last_q     <= LANE1;
      mode_q     <= RR;
      lane_cfg_q <= LANE0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_RESET: begin
          state_q <= ST_INIT;
        end
        ST_INIT: begin
          mode_q     <= bus.mode_cfg;
          lane_cfg_q <= bus.fixed_lane_cfg;
          cnt0_q     <= '0;
          cnt1_q     <= '0;
          last_q     <= LANE1;
          if (!bus.init) begin
            state_q <= ST_IDLE;
          end
        end
        ST_IDLE, ST_ACTIVE: begin
          if (bus.init) begin
            state_q <= ST_INIT;
          end else if (xfer) begin
            state_q <= ST_ACTIVE;
            valid_q <= 1'b1;
            sel_q   <= pick_lane;
            data_q  <= bus.data_in;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
            if (mode_q == RR) begin
              last_q <= pick_lane;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_RESET;
        end
      endcase
    end
  end

  assign bus.ready_out = ready;
  assign bus.selector  = sel_q;
  assign bus.valid_out = valid_q;
  assign bus.data_out  = data_q;
  assign bus.count0    = cnt0_q;
  assign bus.count1    = cnt1_q;
  assign bus.idle_out  = (state_q == ST_IDLE);

endmodule
